conv_window_gen: RTL and testbench

Upstream feeder for conv2d. On a start pulse it streams one IMG_W x IMG_H image of DATA_W-bit pixels out of a synchronous-read image memory, in raster order. Two line FIFOs plus a 3x3 register array build the pixel neighbourhood. Every interior 3x3 window is presented to the convolution stage with a valid/ready handshake and the window's centre coordinates.

---
 rtl/conv_pkg.sv | 25 ++
 rtl/line_fifo.sv | 37 +++
 rtl/conv_window_gen.sv | 183 ++++++++++++++++++
 tb/tb_conv_window_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, state encoding and window packing helper for the conv pipeline
package conv_pkg;

    localparam int DATA_W  = 12;
    localparam int IMG_W   = 50;
    localparam int IMG_H   = 50;
    localparam int ADDR_W  = 17;
    localparam int KSIZE   = 3;
    localparam int COORD_W = 6;
    localparam int NPIX    = IMG_W * IMG_H;
    localparam int WIN_W   = KSIZE * KSIZE * DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    // Bit offset of window element (r,c); r=0 is the top row, c=0 the left column.
    function automatic int win_lsb(input int r, input int c);
        return DATA_W * (KSIZE * r + c);
    endfunction

endpackage

// File: rtl/line_fifo.sv
// rtl/line_fifo.sv - fixed-depth circular line buffer; dout is the sample pushed DEPTH pushes ago
module line_fifo
    import conv_pkg::*;
#(
    parameter int DEPTH = IMG_W,
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    // Read and write share one pointer: the slot about to be overwritten holds the oldest sample.
    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (push) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streams an image from memory and presents every interior 3x3 window
module conv_window_gen
    import conv_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_en,
    input  logic [DATA_W-1:0]  rd_data,
    output logic [WIN_W-1:0]   win,
    output logic [COORD_W-1:0] win_row,
    output logic [COORD_W-1:0] win_col,
    output logic               win_valid,
    input  logic               win_ready,
    output logic               busy,
    output logic               done
);

    state_t state, state_nxt;

    logic               pend;
    logic               skid_valid;
    logic [DATA_W-1:0]  skid_data;
    logic [DATA_W-1:0]  pix;
    logic [COORD_W-1:0] row_in;
    logic [COORD_W-1:0] col_in;
    logic [DATA_W-1:0]  arr [KSIZE][KSIZE];
    logic [DATA_W-1:0]  lf0_out;
    logic [DATA_W-1:0]  lf1_out;
    logic               stall;
    logic               consume;
    logic               frame_go;
    logic               addr_left;
    logic               row_done;

    assign stall     = win_valid && !win_ready;
    // A skidded pixel is always older than anything still in flight, so it goes first.
    assign pix       = skid_valid ? skid_data : rd_data;
    assign consume   = (skid_valid || pend) && !stall;
    assign addr_left = rd_addr < ADDR_W'(NPIX);
    assign row_done  = row_in == COORD_W'(IMG_H);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        frame_go  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                    frame_go  = 1'b1;
                end
            end
            FETCH: begin
                busy  = 1'b1;
                rd_en = addr_left && !stall && !skid_valid;
                if (rd_en && rd_addr == ADDR_W'(NPIX - 1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // Once every pixel is consumed the final window is already in the output register.
                if (row_done && !stall) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nxt = FETCH;
                    frame_go  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_addr    <= '0;
            pend       <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            row_in     <= '0;
            col_in     <= '0;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE; c++) begin
                    arr[r][c] <= '0;
                end
            end
        end else begin
            pend <= rd_en;

            if (pend && stall) begin
                skid_valid <= 1'b1;
                skid_data  <= rd_data;
            end else if (consume) begin
                skid_valid <= 1'b0;
            end

            if (frame_go) begin
                rd_addr <= '0;
                row_in  <= '0;
                col_in  <= '0;
            end else begin
                if (rd_en) begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                end
                if (consume) begin
                    if (col_in == COORD_W'(IMG_W - 1)) begin
                        col_in <= '0;
                        row_in <= row_in + COORD_W'(1);
                    end else begin
                        col_in <= col_in + COORD_W'(1);
                    end
                end
            end

            if (consume) begin
                for (int r = 0; r < KSIZE; r++) begin
                    arr[r][0] <= arr[r][1];
                    arr[r][1] <= arr[r][2];
                end
                arr[0][2] <= lf1_out;
                arr[1][2] <= lf0_out;
                arr[2][2] <= pix;
            end

            // Windows straddling a row wrap or lacking two rows above are never flagged valid.
            if (!stall) begin
                win_valid <= consume && row_in >= COORD_W'(KSIZE - 1)
                                     && col_in >= COORD_W'(KSIZE - 1);
                if (consume) begin
                    win_row <= row_in - COORD_W'(1);
                    win_col <= col_in - COORD_W'(1);
                end
            end
        end
    end

    always_comb begin
        win = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                win[win_lsb(r, c) +: DATA_W] = arr[r][c];
            end
        end
    end

    line_fifo u_line_fifo0 (
        .clk  (clk),
        .rst  (rst),
        .push (consume),
        .din  (pix),
        .dout (lf0_out)
    );

    line_fifo u_line_fifo1 (
        .clk  (clk),
        .rst  (rst),
        .push (consume),
        .din  (lf0_out),
        .dout (lf1_out)
    );

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - directed bench for conv_window_gen with golden window extraction
module tb_conv_window_gen;

    localparam int W    = 50;
    localparam int H    = 50;
    localparam int NWIN = 2304;
    localparam int LIMIT = 20000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         win_ready = 1'b1;
    logic [16:0]  rd_addr;
    logic         rd_en;
    logic [11:0]  rd_data = '0;
    logic [107:0] win;
    logic [5:0]   win_row;
    logic [5:0]   win_col;
    logic         win_valid;
    logic         busy;
    logic         done;

    logic [11:0]  img [W*H];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    conv_window_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .win       (win),
        .win_row   (win_row),
        .win_col   (win_col),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .busy      (busy),
        .done      (done)
    );

    always @(posedge clk) begin
        if (rd_en) rd_data <= img[rd_addr];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [107:0] golden_win(input int k);
        int r;
        int c;
        logic [107:0] g;
        r = 1 + k / 48;
        c = 1 + k % 48;
        g = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                g[12*(3*dr+dc) +: 12] = img[(r-1+dr)*W + (c-1+dc)];
        return g;
    endfunction

    // rmode: 0 ready high, 1 stall at window 10, 2 extra start at window 300,
    //        3 reset at window 500, 4 random ready
    task automatic frame(input bit pre_started, input int rmode, input bit timing, input bit chain);
        int cyc;
        int widx;
        int first_cyc;
        int stall_left;
        int rd_pulses;
        int er;
        int ec;
        bit stall_used;
        bit injected;
        bit prev_stall;
        bit finished;
        bit aborted;
        logic [119:0] hold;
        widx = 0; first_cyc = -1; stall_left = 0; rd_pulses = 0;
        stall_used = 0; injected = 0; prev_stall = 0; finished = 0; aborted = 0;
        hold = '0;
        if (!pre_started) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        if (timing) begin
            chk("first_rd_en", 128'(rd_en), 128'(1));
            chk("first_rd_addr", 128'(rd_addr), 128'(0));
            chk("busy_rise", 128'(busy), 128'(1));
        end
        while (!finished && !aborted) begin
            start = 1'b0;
            if (cyc > LIMIT) begin
                checks++;
                errors++;
                $error("FAIL timeout observed=%0d windows expected=%0d", widx, NWIN);
                aborted = 1;
                break;
            end
            if (prev_stall)
                chk("hold", 128'({win_valid, win, win_row, win_col}), 128'({1'b1, hold}));
            if (done) begin
                chk("done_busy", 128'(busy), 128'(0));
                chk("win_count", 128'(widx), 128'(NWIN));
                if (timing) chk("done_cycle", 128'(cyc), 128'(2503));
                if (chain) start = 1'b1;
                finished = 1;
                break;
            end
            if (rmode == 3 && widx == 500 && win_valid) begin
                rst = 1'b1;
                #1;
                chk("rst_out_a", 128'({rd_addr, rd_en, win_valid, busy, done, win_row, win_col}), 128'(0));
                chk("rst_out_b", 128'(win), 128'(0));
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1;
                break;
            end
            if (rmode == 1 && !stall_used && widx == 10 && win_valid) begin
                stall_left = 5;
                stall_used = 1;
                rd_pulses = 0;
            end
            if (rmode == 2 && !injected && widx == 300 && win_valid) begin
                start = 1'b1;
                injected = 1;
            end
            if (rmode == 4) win_ready = 1'($urandom % 2);
            else            win_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) begin
                if (rd_en) rd_pulses++;
                stall_left--;
                if (stall_left == 0) chk("stall_rd_pulses", 128'(rd_pulses <= 1), 128'(1));
            end
            if (win_valid && first_cyc < 0) begin
                first_cyc = cyc;
                if (timing) chk("first_valid_cycle", 128'(first_cyc), 128'(105));
            end
            if (win_valid && win_ready) begin
                er = 1 + widx / 48;
                ec = 1 + widx % 48;
                chk("win", 128'(win), 128'(golden_win(widx)));
                chk("centre", 128'({win_row, win_col}), 128'({er[5:0], ec[5:0]}));
                if (timing) chk("win_cycle", 128'(cyc), 128'((er + 1) * W + ec + 1 + 3));
                if (rmode == 0 && widx == 48)
                    chk("wrap_elem11", 128'(win[48 +: 12]), 128'(101));
                widx++;
            end
            prev_stall = win_valid && !win_ready;
            hold = {win, win_row, win_col};
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (!chain) start = 1'b0;
        win_ready = 1'b1;
        if (finished && !chain) begin
            @(negedge clk);
            chk("done_pulse_end", 128'({done, busy}), 128'(0));
        end
    endtask

    initial begin
        for (int i = 0; i < W*H; i++) img[i] = 12'(i);
        @(negedge clk);
        chk("reset_a", 128'({rd_addr, rd_en, win_valid, busy, done, win_row, win_col}), 128'(0));
        chk("reset_b", 128'(win), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 128'({rd_en, busy, done, win_valid}), 128'(0));

        frame(1'b0, 0, 1'b1, 1'b0);
        frame(1'b0, 1, 1'b0, 1'b0);
        frame(1'b0, 2, 1'b1, 1'b1);
        frame(1'b1, 0, 1'b1, 1'b0);
        frame(1'b0, 3, 1'b0, 1'b0);
        frame(1'b0, 0, 1'b1, 1'b0);

        for (int i = 0; i < W*H; i++) img[i] = 12'($urandom);
        frame(1'b0, 4, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
